// File: rtl/hbword_pack_if.sv
// Handshake bundle for hbword_pack: decoded hex-code input plus packed-word output.
// "master" is the code source / word sink; "slave" is the packer.
interface hbword_pack_if #(
  parameter int DW = 32,
  parameter int CW = 2
);
  logic              i_stb;
  logic [4:0]        i_bits;
  logic              o_busy;
  logic              o_stb;
  logic [CW+DW-1:0]  o_word;
  logic              i_busy;
  logic              dbg_state;

  modport master (
    output i_stb, i_bits, i_busy,
    input  o_busy, o_stb, o_word, dbg_state
  );

  modport slave (
    input  i_stb, i_bits, i_busy,
    output o_busy, o_stb, o_word, dbg_state
  );
endinterface

// File: rtl/hbword_pack.sv
// Packs a stream of 5-bit hex codes (nibbles, Start, Flush) into {cmd, data} words
// and presents each word on a strobe/busy handshake toward the hexbus master.
module hbword_pack #(
  parameter int DW = 32,
  parameter int CW = 2
) (
  input logic         i_clk,
  input logic         i_reset,
  hbword_pack_if.slave bus
);
  localparam int NN    = DW / 4;
  localparam int CNT_W = $clog2(NN + 1);

  typedef enum logic { IDLE = 1'b0, COLLECT = 1'b1 } state_t;

  // Handshake: a code transfers on i_stb && !o_busy; a word transfers on
  // o_stb && !i_busy. o_stb/o_word hold while stalled; o_busy stalls input then.
  state_t            state, state_nxt;
  logic              o_stb_q;
  logic [CW+DW-1:0]  o_word_q;
  logic [CW-1:0]     p_cmd;
  logic [DW-1:0]     p_data;
  logic [CNT_W-1:0]  p_cnt;

  logic accept, is_nib, is_start, is_flush;
  logic emit, load_start, shift_nib;

  assign bus.o_busy    = o_stb_q && bus.i_busy;
  assign bus.o_stb     = o_stb_q;
  assign bus.o_word    = o_word_q;
  assign bus.dbg_state = state;

  assign accept   = bus.i_stb && !bus.o_busy;
  assign is_nib   = !bus.i_bits[4];
  assign is_start = bus.i_bits[4] && !bus.i_bits[3];
  assign is_flush = bus.i_bits[4] && bus.i_bits[3];

  always_ff @(posedge i_clk) begin
    if (i_reset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (accept && is_start)      state_nxt = COLLECT;
    else if (accept && is_flush) state_nxt = IDLE;
  end

  always_comb begin
    emit       = 1'b0;
    load_start = 1'b0;
    shift_nib  = 1'b0;
    if (accept) begin
      load_start = is_start;
      shift_nib  = is_nib && (state == COLLECT);
      emit       = (is_start || is_flush) && (state == COLLECT);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      p_cmd  <= '0;
      p_data <= '0;
      p_cnt  <= '0;
    end else if (load_start) begin
      p_cmd  <= bus.i_bits[CW-1:0];
      p_data <= '0;
      p_cnt  <= '0;
    end else if (shift_nib) begin
      // Overflow keeps shifting so the most recent NN nibbles survive.
      p_data <= (p_data << 4) | DW'(bus.i_bits[3:0]);
      if (p_cnt != CNT_W'(NN)) p_cnt <= p_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_stb_q  <= 1'b0;
      o_word_q <= '0;
    end else if (emit) begin
      o_stb_q  <= 1'b1;
      o_word_q <= {p_cmd, p_data};
    end else if (o_stb_q && !bus.i_busy) begin
      o_stb_q  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_hbword_pack.sv
// Directed bench for hbword_pack: drives code sequences, scoreboards every
// consumed word against hand-computed values, and checks handshake timing.
module tb_hbword_pack;
  localparam int DW = 32;
  localparam int CW = 2;
  localparam int W  = CW + DW;
  localparam logic [4:0] FLUSH = 5'b11000;

  logic i_clk = 1'b0;
  logic i_reset;

  hbword_pack_if #(.DW(DW), .CW(CW)) bus ();

  hbword_pack #(.DW(DW), .CW(CW)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (bus)
  );

  always #5 i_clk = ~i_clk;

  int n_total = 0;
  int n_bad   = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] start_code(input logic [2:0] c);
    return {2'b10, c};
  endfunction

  function automatic logic [W-1:0] mk(input logic [CW-1:0] c, input logic [DW-1:0] d);
    return {c, d};
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Present one code and hold it until accepted; returns #1 after the accept edge.
  task automatic send(input logic [4:0] code);
    bit done = 0;
    bus.i_stb  = 1'b1;
    bus.i_bits = code;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge i_clk);
      if (!bus.o_busy) done = 1;
      tick();
    end
    bus.i_stb = 1'b0;
    if (!done) check("send_timeout", W'(bus.o_busy), '0);
  endtask

  // Scoreboard: each cycle a word is consumed it must match the next expected word.
  initial begin
    forever begin
      @(negedge i_clk);
      if (!i_reset && bus.o_stb && !bus.i_busy) begin
        if (exp_q.size() == 0) check("unexpected_word", W'(bus.o_stb), '0);
        else                   check("word", bus.o_word, exp_q.pop_front());
      end
    end
  end

  initial begin
    bus.i_stb  = 1'b0;
    bus.i_bits = '0;
    bus.i_busy = 1'b0;
    i_reset    = 1'b1;
    repeat (3) tick();
    check("rst_stb",   W'(bus.o_stb), '0);
    check("rst_word",  bus.o_word, '0);
    check("rst_busy",  W'(bus.o_busy), '0);
    check("rst_state", W'(bus.dbg_state), '0);
    i_reset = 1'b0;
    tick();

    // Full 8-nibble word
    exp_q.push_back(mk(2'b10, 32'h12345678));
    send(start_code(3'd2));
    for (int i = 1; i <= 8; i++) send(5'(i));
    send(FLUSH);
    check("t1_stb_hi", W'(bus.o_stb), W'(1));
    check("t1_word", bus.o_word, mk(2'b10, 32'h12345678));
    tick();
    check("t1_stb_lo", W'(bus.o_stb), '0);

    // Start-terminated short word followed by a flushed one
    exp_q.push_back(mk(2'b01, 32'h000000A5));
    exp_q.push_back(mk(2'b11, 32'h0000000F));
    send(start_code(3'd1));
    send(5'hA);
    send(5'h5);
    send(start_code(3'd3));
    check("t2_stb_a", W'(bus.o_stb), W'(1));
    send(5'hF);
    check("t2_pulse_a", W'(bus.o_stb), '0);
    send(FLUSH);
    check("t2_stb_b", W'(bus.o_stb), W'(1));
    tick();
    check("t2_pulse_b", W'(bus.o_stb), '0);

    // Stall: word held while busy, then consume and emit on the same edge
    exp_q.push_back(mk(2'b01, 32'h0000000C));
    exp_q.push_back(mk(2'b10, 32'h0));
    exp_q.push_back(mk(2'b00, 32'h0));
    send(start_code(3'd1));
    send(5'hC);
    bus.i_busy = 1'b1;
    send(start_code(3'd2));
    bus.i_stb  = 1'b1;
    bus.i_bits = start_code(3'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge i_clk);
      check("t3_busy", W'(bus.o_busy), W'(1));
      check("t3_hold", bus.o_word, mk(2'b01, 32'h0000000C));
    end
    tick();
    bus.i_busy = 1'b0;
    tick();
    bus.i_stb = 1'b0;
    check("t3_nobubble_stb", W'(bus.o_stb), W'(1));
    check("t3_nobubble_word", bus.o_word, mk(2'b10, 32'h0));
    send(FLUSH);
    tick();

    // Overflow keeps the last eight nibbles
    exp_q.push_back(mk(2'b00, 32'h3456789A));
    send(start_code(3'd0));
    for (int i = 1; i <= 10; i++) send(5'(i));
    send(FLUSH);
    tick();

    // Nibbles and Flush in IDLE are ignored
    send(5'h7);
    send(5'h7);
    send(FLUSH);
    check("t5_idle_stb", W'(bus.o_stb), '0);
    tick();
    check("t5_idle_stb2", W'(bus.o_stb), '0);
    check("t5_idle_state", W'(bus.dbg_state), '0);
    exp_q.push_back(mk(2'b10, 32'h0));
    send(start_code(3'd2));
    send(FLUSH);
    check("t5_empty_word", bus.o_word, mk(2'b10, 32'h0));
    tick();

    // Reset while a word is held and another is pending
    send(start_code(3'd1));
    send(5'h1);
    send(5'h2);
    send(5'h3);
    bus.i_busy = 1'b1;
    send(start_code(3'd3));
    check("t6_held_stb", W'(bus.o_stb), W'(1));
    check("t6_held_word", bus.o_word, mk(2'b01, 32'h00000123));
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    check("t6_rst_stb", W'(bus.o_stb), '0);
    check("t6_rst_busy", W'(bus.o_busy), '0);
    check("t6_rst_word", bus.o_word, '0);
    bus.i_busy = 1'b0;
    send(FLUSH);
    for (int k = 0; k < 3; k++) begin
      check("t6_no_emit", W'(bus.o_stb), '0);
      tick();
    end

    repeat (3) tick();
    check("drain", W'(exp_q.size()), '0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
